fetch: RTL
==========

FETCH -- requirements
Module: fetch

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port mem_addr, output, 16 bits: instruction memory word address.
REQ-004 SHALL have port mem_rd_en, output, 1 bit: read request; memory returns mem_rdata exactly 1 cycle later.
REQ-005 SHALL have port mem_rdata, input, 16 bits: read data for the previous cycle's request.
REQ-006 SHALL have port stall, input, 1 bit: decode cannot accept the current head this cycle.
REQ-007 SHALL have port flush, input, 1 bit: redirect to branch_target; kill the in-flight request and all buffered entries.
REQ-008 SHALL have port branch_target, input, 16 bits: redirect address; valid when flush=1.
REQ-009 SHALL have port halt, input, 1 bit: freeze all fetch state.
REQ-010 SHALL have ports instr_out (16b), pc_out (16b) and bubble_out (1b), all outputs: head instruction, its address, and head-invalid flag, presented to decode.

Function
REQ-011 SHALL hold state: pc (next address to issue), inflight_valid, inflight_pc, and a 2-entry {pc, instr} buffer with a 2-bit count.
REQ-012 SHALL select the head as the oldest buffer entry when count>0, otherwise {inflight_pc, mem_rdata} when inflight_valid=1.
REQ-013 SHALL drive bubble_out=1 when there is no head, and SHALL drive instr_out=16'h0000 whenever bubble_out=1.
REQ-014 SHALL consume the head in any cycle with stall=0, halt=0 and flush=0.
REQ-015 SHALL push an unconsumed in-flight response into the buffer, and SHALL also push it whenever count>0, so that program order is preserved.
REQ-016 SHALL issue a request (mem_rd_en=1, mem_addr=pc, pc<=pc+1, inflight_pc<=pc, inflight_valid<=1) only when halt=0, stall=0, flush=0 and the post-cycle count is <=1; otherwise it SHALL set inflight_valid<=0.
REQ-017 SHALL increment pc modulo 2^16, so that 16'hFFFF is followed by 16'h0000.
REQ-018 On flush=1 with halt=0, SHALL drive mem_rd_en=1 and mem_addr=branch_target combinationally, and SHALL set pc<=branch_target+1, inflight_pc<=branch_target, inflight_valid<=1 and count<=0; the next cycle's head SHALL be the target instruction (1-cycle redirect latency).
REQ-019 SHALL give flush priority over stall; SHALL drop the in-flight response of the flush cycle.
REQ-020 On halt=1, SHALL drive mem_rd_en=0 and SHALL hold pc, count, buffer and inflight_pc; flush and stall SHALL be ignored.
REQ-021 On halt=1 with inflight_valid=1, SHALL capture mem_rdata into the buffer (count permitting), so that no fetched word is lost.
REQ-022 After halt deasserts, SHALL resume with the same head and pc it held before the halt.
REQ-023 SHALL never push into a full buffer; SHALL never issue a request when count=2.

Reset
REQ-024 While rst_n=0, SHALL force pc=16'h0000, count=0, inflight_valid=0, mem_rd_en=0, mem_addr=16'h0000, bubble_out=1, instr_out=16'h0000, pc_out=16'h0000.
REQ-025 In the first clock edge after rst_n rises, SHALL issue address 0; the first valid head SHALL appear one cycle later.
REQ-026 If reset asserts mid-operation, SHALL discard any in-flight response and buffer contents.

Structure
REQ-027 Shared package pipeline_pkg SHALL hold RESET_PC=16'h0000, NOP_INSTR=16'h0000, FETCH_BUF_DEPTH=2 and the {pc, instr} entry typedef.
REQ-028 The buffer SHALL be a sub-module fetch_buf: a 2-entry FIFO with push, pop, clear, count, and head outputs.

Verification
REQ-029 Reset release, mem[0..3]=A000,A001,A002,A003, no stall: heads appear one per cycle from cycle 2, pc_out=0,1,2,3, with a single initial bubble.
REQ-030 stall=1 for 3 cycles while head pc=2: pc_out holds 2, no skipped or duplicated instruction afterwards, and count never exceeds 2.
REQ-031 flush=1 with branch_target=16'h0040 while stall=1: next head has pc_out=0x0040 and buffered/in-flight words are discarded.
REQ-032 pc=16'hFFFF, free-running: the next issued address is 16'h0000.
REQ-033 halt=1 for 4 cycles with inflight_valid=1: mem_rd_en=0 throughout, and after release the stream continues in order.
REQ-034 rst_n asserted with count=2: outputs go to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline constants and the fetch buffer entry type.
package pipeline_pkg;

   localparam logic [15:0] RESET_PC        = 16'h0000;
   localparam logic [15:0] NOP_INSTR       = 16'h0000;
   localparam int unsigned FETCH_BUF_DEPTH = 2;

   typedef struct packed {
      logic [15:0] pc;
      logic [15:0] instr;
   } fetch_entry_t;

   // Program counter advance; wraps naturally at 16 bits.
   function automatic logic [15:0] pc_next(input logic [15:0] pc);
      return pc + 16'd1;
   endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch-stage bus: instruction memory port, decode-side controls and head outputs.
interface fetch_if;

   logic [15:0] mem_addr;
   logic        mem_rd_en;
   logic [15:0] mem_rdata;
   logic        stall;
   logic        flush;
   logic [15:0] branch_target;
   logic        halt;
   logic [15:0] instr_out;
   logic [15:0] pc_out;
   logic        bubble_out;

   modport master (
      output mem_addr, mem_rd_en, instr_out, pc_out, bubble_out,
      input  mem_rdata, stall, flush, branch_target, halt
   );

   modport slave (
      input  mem_addr, mem_rd_en, instr_out, pc_out, bubble_out,
      output mem_rdata, stall, flush, branch_target, halt
   );

endinterface

// File: rtl/fetch_buf.sv
// Two-entry {pc, instr} FIFO holding fetched words that decode has not yet taken.
module fetch_buf
   import pipeline_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  fetch_entry_t push_data,
   input  logic         pop,
   input  logic         clear,
   output logic [1:0]   count,
   output fetch_entry_t head
);

   localparam logic [1:0] FULL = 2'(FETCH_BUF_DEPTH);

   fetch_entry_t entries [FETCH_BUF_DEPTH];
   logic         wr_ptr;
   logic         rd_ptr;
   logic         do_push;
   logic         do_pop;

   always_comb begin
      do_pop  = pop && (count != 2'd0);
      do_push = push && ((count != FULL) || do_pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count  <= 2'd0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
      end else if (clear) begin
         count  <= 2'd0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= ~wr_ptr;
         if (do_pop)  rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, do_push} - {1'b0, do_pop};
      end
   end

   // Storage needs no reset: count gates every read of it.
   always_ff @(posedge clk) begin
      if (do_push && !clear) entries[wr_ptr] <= push_data;
   end

   assign head = entries[rd_ptr];

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(push && !pop && count == FULL));
   a_count_range: assert property (@(posedge clk) disable iff (!rst_n)
      count <= FULL);

endmodule

// File: rtl/fetch.sv
// Instruction fetch: one request per cycle, 1-cycle memory latency, 2-entry skid buffer.
module fetch
   import pipeline_pkg::*;
(
   input  logic     clk,
   input  logic     rst_n,
   fetch_if.master  bus
);

   logic [15:0]  pc;
   logic [15:0]  inflight_pc;
   logic         inflight_valid;

   logic [1:0]   count;
   fetch_entry_t buf_head;
   fetch_entry_t push_data;
   fetch_entry_t head;

   logic         head_valid;
   logic         redirect;
   logic         consume;
   logic         push;
   logic         pop;
   logic [1:0]   post_count;
   logic         issue;

   always_comb begin
      head_valid = (count != 2'd0) || inflight_valid;
      push_data  = '{pc: inflight_pc, instr: bus.mem_rdata};
      head       = (count != 2'd0) ? buf_head : push_data;
      redirect   = bus.flush && !bus.halt;
      consume    = head_valid && !bus.stall && !bus.halt && !bus.flush;
      pop        = consume && (count != 2'd0);
      // A returning word goes to the buffer unless it is the head and taken now;
      // under halt it is parked there so nothing fetched is lost.
      if (bus.halt)
         push = inflight_valid && (count != 2'd2);
      else
         push = inflight_valid && !bus.flush && ((count != 2'd0) || !consume);
      post_count = count + {1'b0, push} - {1'b0, pop};
      issue      = !bus.halt && !bus.stall && !bus.flush && (post_count <= 2'd1);
   end

   // Reset gating keeps the memory port quiet even while inputs still toggle.
   assign bus.mem_rd_en  = rst_n && (issue || redirect);
   assign bus.mem_addr   = !rst_n ? RESET_PC : (redirect ? bus.branch_target : pc);
   assign bus.bubble_out = !head_valid;
   assign bus.instr_out  = head_valid ? head.instr : NOP_INSTR;
   assign bus.pc_out     = head_valid ? head.pc : RESET_PC;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc             <= RESET_PC;
         inflight_pc    <= RESET_PC;
         inflight_valid <= 1'b0;
      end else if (redirect) begin
         pc             <= pc_next(bus.branch_target);
         inflight_pc    <= bus.branch_target;
         inflight_valid <= 1'b1;
      end else if (issue) begin
         pc             <= pc_next(pc);
         inflight_pc    <= pc;
         inflight_valid <= 1'b1;
      end else begin
         inflight_valid <= 1'b0;
      end
   end

   fetch_buf u_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .clear     (redirect),
      .count     (count),
      .head      (buf_head)
   );

   a_no_issue_full: assert property (@(posedge clk) disable iff (!rst_n)
      !(issue && count == 2'd2));
   a_halt_quiet: assert property (@(posedge clk) disable iff (!rst_n)
      !(bus.halt && bus.mem_rd_en));

endmodule
